// File: rtl/alu_datapath_pkg.sv
// ---------------------------------------------------------------------------
// alu_datapath_pkg
// Shared definitions for the ALU datapath slice: datapath widths, the
// sequencer state type, ALU opcode constants and PSR flag bit positions.
// Anything that has to agree between the datapath, the register file and
// the external ALU lives here.
// ---------------------------------------------------------------------------
package alu_datapath_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int FLAG_W = 5;
    localparam int IMM_W  = 8;

    // Sequencer states: one instruction walks IDLE -> EXEC -> WB.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Opcode groups live in [7:4], operations in [3:0].
    localparam logic [3:0] GRP_ARITH = 4'h0;
    localparam logic [3:0] GRP_SHIFT = 4'h4;

    localparam logic [7:0] OP_AND  = {GRP_ARITH, 4'h1};
    localparam logic [7:0] OP_OR   = {GRP_ARITH, 4'h2};
    localparam logic [7:0] OP_XOR  = {GRP_ARITH, 4'h3};
    localparam logic [7:0] OP_ADD  = {GRP_ARITH, 4'h5};
    localparam logic [7:0] OP_ADDU = {GRP_ARITH, 4'h6};
    localparam logic [7:0] OP_SUB  = {GRP_ARITH, 4'h9};
    localparam logic [7:0] OP_CMP  = {GRP_ARITH, 4'hB};
    localparam logic [7:0] OP_MOV  = {GRP_ARITH, 4'hD};
    localparam logic [7:0] OP_LSH  = {GRP_SHIFT, 4'h4};

    // PSR / ALU flag bit positions, {Z,C,O,L,N}.
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    // Immediates are signed bytes widened to the datapath width.
    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // CMP only produces flags; every other opcode writes its destination.
    function automatic logic writes_back(input logic [7:0] opcode);
        return opcode != OP_CMP;
    endfunction

endpackage

// File: rtl/alu_datapath_regfile.sv
// ---------------------------------------------------------------------------
// alu_datapath_regfile
// General-purpose register array for the ALU datapath.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears all)
//   rd_addr_a/rd_data_a asynchronous read port A (destination operand)
//   rd_addr_b/rd_data_b asynchronous read port B (source operand)
//   dbg_addr/dbg_data   asynchronous debug read port
//   wr_en/wr_addr/wr_data synchronous write port
//
// Reads are purely combinational from the stored array, so a read of the
// register being written returns the old value until the write edge.
// ---------------------------------------------------------------------------
module alu_datapath_regfile
    import alu_datapath_pkg::*;
#(
    parameter int NREGS = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // Addresses beyond a reduced NREGS read as zero and ignore writes.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NREGS;
    endfunction

    // Three independent combinational read ports.
    assign rd_data_a = addr_ok(rd_addr_a) ? regs[rd_addr_a] : '0;
    assign rd_data_b = addr_ok(rd_addr_b) ? regs[rd_addr_b] : '0;
    assign dbg_data  = addr_ok(dbg_addr)  ? regs[dbg_addr]  : '0;

    // Single write port; reset clears every register immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && addr_ok(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// ---------------------------------------------------------------------------
// alu_datapath
// Three-cycle sequencer wrapped around an external ALU. An instruction is
// accepted in IDLE (operands read and latched), presented to the ALU in
// EXEC (result and flags captured), and retired in WB (register and PSR
// written, done pulsed).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   instr_valid / instr_ready   instruction handshake (ready only in IDLE)
//   instr_opcode, instr_rdest, instr_rsrc, instr_imm, instr_imm_sel
//                               instruction fields
//   alu_dst, alu_src, alu_opcode, alu_c_in   operands to the external ALU
//   alu_result, alu_flags       results from the external ALU
//   psr                         registered {Z,C,O,L,N}
//   done                        one-cycle retire pulse
//   dbg_addr / dbg_data         combinational register read-back
// ---------------------------------------------------------------------------
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int NREGS = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_rdest,
    input  logic [ADDR_W-1:0] instr_rsrc,
    input  logic [IMM_W-1:0]  instr_imm,
    input  logic              instr_imm_sel,
    output logic [DATA_W-1:0] alu_dst,
    output logic [DATA_W-1:0] alu_src,
    output logic [7:0]        alu_opcode,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] psr,
    output logic              done,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic              ready_q;
    logic              done_q;

    // Holding registers: the accepted instruction and its operand values.
    logic [7:0]        hold_opcode;
    logic [ADDR_W-1:0] hold_rdest;
    logic [DATA_W-1:0] hold_dst;
    logic [DATA_W-1:0] hold_src;

    // Result registers captured at the end of EXEC.
    logic [DATA_W-1:0] res_value;
    logic [FLAG_W-1:0] res_flags;
    logic [FLAG_W-1:0] psr_q;

    logic [DATA_W-1:0] rf_dst_data;
    logic [DATA_W-1:0] rf_src_data;
    logic              wb_write;

    // The write lands on the WB -> IDLE edge, so the next accept in IDLE
    // already reads the retired value and no forwarding path is needed.
    assign wb_write = (state == ST_WB) && writes_back(hold_opcode);

    alu_datapath_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (instr_rdest),
        .rd_data_a (rf_dst_data),
        .rd_addr_b (instr_rsrc),
        .rd_data_b (rf_src_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wb_write),
        .wr_addr   (hold_rdest),
        .wr_data   (res_value)
    );

    // Sequencer with registered handshake outputs. ready/done are updated
    // alongside the state so they always describe the current state.
    // An abort by reset leaves regfile and psr at their cleared values
    // because both are reset on the same asynchronous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            hold_opcode <= '0;
            hold_rdest  <= '0;
            hold_dst    <= '0;
            hold_src    <= '0;
            res_value   <= '0;
            res_flags   <= '0;
            psr_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        hold_opcode <= instr_opcode;
                        hold_rdest  <= instr_rdest;
                        hold_dst    <= rf_dst_data;
                        hold_src    <= instr_imm_sel ? sext_imm(instr_imm)
                                                     : rf_src_data;
                        ready_q     <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_value <= alu_result;
                    res_flags <= alu_flags;
                    done_q    <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    psr_q   <= res_flags;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operands come straight from the holding registers; outside EXEC
    // they simply keep showing the last accepted instruction.
    assign alu_dst     = hold_dst;
    assign alu_src     = hold_src;
    assign alu_opcode  = hold_opcode;
    assign alu_c_in    = psr_q[FLAG_C];

    assign instr_ready = ready_q;
    assign done        = done_q;
    assign psr         = psr_q;

endmodule
